// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream packet FIFO: buffering-mode encodings
// and the stored entry width.
package axis_pkg;

    localparam int MODE_CUT_THROUGH = 0;
    localparam int MODE_PACKET      = 1;

    // Entry layout is {TLAST, TUSER, TSTRB, TDATA}.
    function automatic int entry_width(int data_width, int user_width);
        return data_width + data_width / 8 + user_width + 1;
    endfunction

endpackage

// File: rtl/packet_if.sv
// AXI4-Stream beat bundle. The beat struct is parametrised here so both FIFO
// ports share one layout.
interface packet #(
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 3
);
    localparam int DATA_BYTES = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  last;
        logic [USER_WIDTH-1:0] user;
        logic [DATA_BYTES-1:0] strb;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    beat_t beat;
    logic  valid;
    logic  ready;

    modport slave  (input beat, input valid, output ready);
    modport master (output beat, output valid, input ready);
endinterface

// File: rtl/axis_fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one
// asynchronous read port.
module axis_fifo_mem #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/axis_packet_fifo_core.sv
// FIFO control: pointers, packet counting and the cut-through / store-and-forward
// release rule, operating on packet interface modports.
module axis_packet_fifo_core
    import axis_pkg::*;
#(
    parameter int  DATA_WIDTH  = 128,
    parameter int  USER_WIDTH  = 3,
    parameter int  DEPTH       = 16,
    parameter int  PACKET_MODE = MODE_CUT_THROUGH,
    localparam int PW          = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    packet.slave          s,
    packet.master         m,
    output logic [PW-1:0] occupancy,
    output logic [PW-1:0] pkt_count
);
    localparam int AW      = PW - 1;
    localparam int ENTRY_W = entry_width(DATA_WIDTH, USER_WIDTH);

    logic [PW-1:0]      wr_ptr, rd_ptr, pkts;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;
    logic               full, empty, wr_en, rd_en, wr_last, rd_last, release_ok;

    assign wr_entry = s.beat;
    assign m.beat   = rd_entry;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // Ready looks only at stored state, so a pop never opens a slot in the same cycle.
    assign s.ready = !rst && !full;
    assign m.valid = !rst && !empty && release_ok;

    assign wr_en   = s.valid && s.ready;
    assign rd_en   = m.valid && m.ready;
    assign wr_last = wr_en && wr_entry[ENTRY_W-1];
    assign rd_last = rd_en && rd_entry[ENTRY_W-1];

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        release_ok = 1'b1;
        case (PACKET_MODE)
            MODE_CUT_THROUGH: release_ok = 1'b1;
            // Full fallback lets packets longer than DEPTH through instead of deadlocking.
            MODE_PACKET:      release_ok = (pkts != '0) || full;
            default:          release_ok = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            pkts   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            if (wr_last && !rd_last)      pkts <= pkts + PW'(1);
            else if (rd_last && !wr_last) pkts <= pkts - PW'(1);
        end
    end

    assign occupancy = wr_ptr - rd_ptr;
    assign pkt_count = pkts;

    axis_fifo_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );
endmodule

// File: rtl/axis_packet_fifo.sv
// AXI4-Stream FIFO top: maps the discrete stream ports onto packet interfaces
// and instantiates the FIFO core.
module axis_packet_fifo
    import axis_pkg::*;
#(
    parameter int  DATA_WIDTH  = 128,
    parameter int  DATA_BYTES  = DATA_WIDTH / 8,
    parameter int  USER_WIDTH  = 3,
    parameter int  DEPTH       = 16,
    parameter int  PACKET_MODE = MODE_CUT_THROUGH,
    localparam int PW          = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_TDATA,
    input  logic [DATA_BYTES-1:0] s_TSTRB,
    input  logic [USER_WIDTH-1:0] s_TUSER,
    input  logic                  s_TLAST,
    input  logic                  s_TVALID,
    output logic                  s_TREADY,
    output logic [DATA_WIDTH-1:0] m_TDATA,
    output logic [DATA_BYTES-1:0] m_TSTRB,
    output logic [USER_WIDTH-1:0] m_TUSER,
    output logic                  m_TLAST,
    output logic                  m_TVALID,
    input  logic                  m_TREADY,
    output logic [PW-1:0]         occupancy,
    output logic [PW-1:0]         pkt_count
);
    packet #(.DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH)) s_if ();
    packet #(.DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH)) m_if ();

    assign s_if.beat  = {s_TLAST, s_TUSER, s_TSTRB, s_TDATA};
    assign s_if.valid = s_TVALID;
    assign s_TREADY   = s_if.ready;

    assign m_TDATA    = m_if.beat.data;
    assign m_TSTRB    = m_if.beat.strb;
    assign m_TUSER    = m_if.beat.user;
    assign m_TLAST    = m_if.beat.last;
    assign m_TVALID   = m_if.valid;
    assign m_if.ready = m_TREADY;

    axis_packet_fifo_core #(
        .DATA_WIDTH  (DATA_WIDTH),
        .USER_WIDTH  (USER_WIDTH),
        .DEPTH       (DEPTH),
        .PACKET_MODE (PACKET_MODE)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .s         (s_if.slave),
        .m         (m_if.master),
        .occupancy (occupancy),
        .pkt_count (pkt_count)
    );
endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: a cut-through instance (index 0) and a packet-mode
// instance (index 1) checked every cycle against a queue model, plus literal checks.
module tb_axis_packet_fifo;
    localparam int DW    = 128;
    localparam int DB    = DW / 8;
    localparam int UW    = 3;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH) + 1;
    localparam int EW    = DW + DB + UW + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata [2];
    logic [DB-1:0] s_tstrb [2];
    logic [UW-1:0] s_tuser [2];
    logic          s_tlast [2];
    logic          s_tvalid[2];
    logic          s_tready[2];
    logic [DW-1:0] m_tdata [2];
    logic [DB-1:0] m_tstrb [2];
    logic [UW-1:0] m_tuser [2];
    logic          m_tlast [2];
    logic          m_tvalid[2];
    logic          m_tready[2];
    logic [PW-1:0] occupancy[2];
    logic [PW-1:0] pkt_count[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axis_packet_fifo #(
            .DATA_WIDTH(DW), .DATA_BYTES(DB), .USER_WIDTH(UW),
            .DEPTH(DEPTH), .PACKET_MODE(g)
        ) dut (
            .clk(clk), .rst(rst),
            .s_TDATA(s_tdata[g]), .s_TSTRB(s_tstrb[g]), .s_TUSER(s_tuser[g]),
            .s_TLAST(s_tlast[g]), .s_TVALID(s_tvalid[g]), .s_TREADY(s_tready[g]),
            .m_TDATA(m_tdata[g]), .m_TSTRB(m_tstrb[g]), .m_TUSER(m_tuser[g]),
            .m_TLAST(m_tlast[g]), .m_TVALID(m_tvalid[g]), .m_TREADY(m_tready[g]),
            .occupancy(occupancy[g]), .pkt_count(pkt_count[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each FIFO is a queue of {last,user,strb,data}; everything the outputs
    // must show is derived from the queue contents.
    logic [EW-1:0] q [2][$];
    bit            prev_hold[2];
    logic [EW-1:0] prev_head[2];
    bit            src_done[2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int n, nlast;
            bit exp_ready, exp_valid;
            logic [EW-1:0] act;
            n = q[d].size();
            nlast = 0;
            for (int i = 0; i < n; i++) nlast += int'(q[d][i][EW-1]);
            exp_ready = !rst && (n != DEPTH);
            exp_valid = !rst && (n != 0) && (d == 0 || nlast != 0 || n == DEPTH);
            act = {m_tlast[d], m_tuser[d], m_tstrb[d], m_tdata[d]};
            check($sformatf("d%0d s_TREADY", d), s_tready[d], exp_ready);
            check($sformatf("d%0d m_TVALID", d), m_tvalid[d], exp_valid);
            check($sformatf("d%0d occupancy", d), occupancy[d], n);
            check($sformatf("d%0d pkt_count", d), pkt_count[d], nlast);
            check($sformatf("d%0d occupancy<=DEPTH", d), occupancy[d] <= DEPTH, 1);
            if (exp_valid) check($sformatf("d%0d payload", d), act, q[d][0]);
            if (prev_hold[d]) begin
                check($sformatf("d%0d TVALID held", d), m_tvalid[d], 1);
                check($sformatf("d%0d payload held", d), act, prev_head[d]);
            end
            prev_hold[d] = m_tvalid[d] && !m_tready[d] && !rst;
            prev_head[d] = act;
            if (rst) begin
                q[d].delete();
            end else begin
                if (exp_valid && m_tready[d]) void'(q[d].pop_front());
                if (exp_ready && s_tvalid[d])
                    q[d].push_back({s_tlast[d], s_tuser[d], s_tstrb[d], s_tdata[d]});
            end
        end
    end

    function automatic logic [EW-1:0] make_beat(input int i, input bit last);
        logic [DW-1:0] data;
        data = {4{32'(i) ^ 32'hC0DE_0000}} ^ {32'(i * 7), 96'h0};
        return {last, 3'(i), 16'(i * 16'h1357) ^ 16'hA5A5, data};
    endfunction

    function automatic logic [EW-1:0] rand_beat(input bit last);
        return {last, 3'($urandom), 16'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_beat(input int d, input logic [EW-1:0] beat);
        int budget;
        budget = 300;
        {s_tlast[d], s_tuser[d], s_tstrb[d], s_tdata[d]} = beat;
        s_tvalid[d] = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready[d]) break;
            budget--;
            if (budget == 0) begin
                check($sformatf("d%0d send timeout", d), s_tready[d], 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_packet(input int d, input int base, input int len, input bit all_last);
        for (int i = 0; i < len; i++) send_beat(d, make_beat(base + i, all_last || (i == len - 1)));
        s_tvalid[d] = 1'b0;
    endtask

    task automatic wait_empty(input int d);
        int budget;
        budget = 500;
        m_tready[d] = 1'b1;
        while (q[d].size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) check($sformatf("d%0d drain timeout", d), occupancy[d], 0);
        m_tready[d] = 1'b0;
    endtask

    task automatic rand_src(input int d);
        int gap;
        for (int i = 0; i < 1000; i++) begin
            gap = $urandom_range(0, 2);
            s_tvalid[d] = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            send_beat(d, rand_beat(i == 999 || $urandom_range(0, 5) == 0));
        end
        s_tvalid[d] = 1'b0;
        src_done[d] = 1'b1;
    endtask

    task automatic rand_sink(input int d);
        int budget;
        budget = 20000;
        while ((!src_done[d] || q[d].size() != 0) && budget > 0) begin
            m_tready[d] = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) check($sformatf("d%0d random drain timeout", d), occupancy[d], 0);
        m_tready[d] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s_tdata[d] = '0; s_tstrb[d] = '0; s_tuser[d] = '0; s_tlast[d] = 1'b0;
            s_tvalid[d] = 1'b0; m_tready[d] = 1'b0; src_done[d] = 1'b0;
        end

        // Reset then idle.
        repeat (3) @(negedge clk);
        check("rst s_TREADY d0", s_tready[0], 0);
        check("rst m_TVALID d1", m_tvalid[1], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-rst s_TREADY d0", s_tready[0], 1);
        check("post-rst occupancy d0", occupancy[0], 0);
        check("post-rst pkt_count d1", pkt_count[1], 0);
        @(posedge clk); #1;

        // Cut-through, 20-beat packet with the sink stalled.
        fork
            send_packet(0, 16'h100, 20, 1'b0);
            begin
                @(negedge clk);
                check("ct m_TVALID before write", m_tvalid[0], 0);
                @(negedge clk);
                check("ct m_TVALID cycle 1", m_tvalid[0], 1);
                check("ct occupancy cycle 1", occupancy[0], 1);
                repeat (15) @(negedge clk);
                check("ct occupancy full", occupancy[0], 16);
                check("ct s_TREADY full", s_tready[0], 0);
                repeat (2) @(negedge clk);
                check("ct occupancy stalled", occupancy[0], 16);
                @(posedge clk); #1;
                m_tready[0] = 1'b1;
            end
        join
        wait_empty(0);
        @(negedge clk);
        check("ct drained occupancy", occupancy[0], 0);
        @(posedge clk); #1;

        // Packet mode, 4-beat packet with the sink always ready.
        m_tready[1] = 1'b1;
        fork
            send_packet(1, 16'h200, 4, 1'b0);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check($sformatf("pkt m_TVALID low %0d", i), m_tvalid[1], 0);
                end
                @(negedge clk);
                check("pkt m_TVALID after last", m_tvalid[1], 1);
                check("pkt pkt_count 1", pkt_count[1], 1);
                check("pkt occupancy 4", occupancy[1], 4);
                repeat (4) @(negedge clk);
                check("pkt pkt_count back to 0", pkt_count[1], 0);
                check("pkt occupancy back to 0", occupancy[1], 0);
            end
        join
        wait_empty(1);
        @(posedge clk); #1;

        // Packet mode, 20-beat packet: full fallback must release it.
        m_tready[1] = 1'b1;
        fork
            send_packet(1, 16'h300, 20, 1'b0);
            begin
                repeat (17) @(negedge clk);
                check("fallback m_TVALID", m_tvalid[1], 1);
                check("fallback occupancy", occupancy[1], 16);
                check("fallback pkt_count", pkt_count[1], 0);
            end
        join
        wait_empty(1);
        @(negedge clk);
        check("fallback drained", occupancy[1], 0);
        @(posedge clk); #1;

        // Simultaneous write and pop at occupancy 8, all beats carry TLAST.
        send_packet(0, 16'h400, 8, 1'b1);
        m_tready[0] = 1'b1;
        fork
            send_packet(0, 16'h500, 3 * DEPTH, 1'b1);
            for (int i = 0; i < 3 * DEPTH; i++) begin
                @(negedge clk);
                check($sformatf("steady occupancy %0d", i), occupancy[0], 8);
                check($sformatf("steady pkt_count %0d", i), pkt_count[0], 8);
            end
        join
        wait_empty(0);
        @(posedge clk); #1;

        // Reset mid-packet discards the partial packet.
        send_packet(1, 16'h600, 3, 1'b0);
        s_tlast[1] = 1'b0;
        check("partial occupancy", occupancy[1], 3);
        rst = 1'b1;
        @(negedge clk);
        check("mid-rst s_TREADY", s_tready[1], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after mid-rst occupancy", occupancy[1], 0);
        check("after mid-rst s_TREADY", s_tready[1], 1);
        @(posedge clk); #1;

        // Random valid/ready on both instances.
        fork
            rand_src(0);
            rand_src(1);
            rand_sink(0);
            rand_sink(1);
        join
        repeat (2) @(negedge clk);
        check("random end occupancy d0", occupancy[0], 0);
        check("random end occupancy d1", occupancy[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
